// File: rtl/mipi_dphy_pkg.sv
// rtl/mipi_dphy_pkg.sv - shared types and constants for the D-PHY HS transmit path
package mipi_dphy_pkg;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_SYNC  = 2'd1,
    HS_DATA  = 2'd2,
    HS_TRAIL = 2'd3
  } hs_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;
  localparam int         BEAT_W            = 2;
  localparam int         TRAIL_CNT_W       = 4;

endpackage

// File: rtl/tx_hs_pair_shifter.sv
// rtl/tx_hs_pair_shifter.sv - 8-bit load / shift-by-2 register presenting the current bit pair
module tx_hs_pair_shifter (
  input  logic       TxDDRClkHS,
  input  logic       TxRst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  output logic [1:0] pair
);

  logic [7:0] sr;

  always_ff @(posedge TxDDRClkHS or posedge TxRst) begin
    if (TxRst) begin
      sr <= '0;
    end else if (en) begin
      if (load) begin
        sr <= load_data;
      end else if (shift) begin
        sr <= {2'b00, sr[7:2]};
      end
    end
  end

  assign pair = sr[1:0];

endmodule

// File: rtl/tx_hs_serializer.sv
// rtl/tx_hs_serializer.sv - PPI byte to DDR bit-pair serializer with sync leader and HS trail
module tx_hs_serializer
  import mipi_dphy_pkg::*;
#(
  parameter int         TRAIL_CYCLES = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       TxDDRClkHS,
  input  logic       TxRst,
  input  logic       ser_en,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       Serial_B1,
  output logic       Serial_B2,
  output logic       hs_active
);

  localparam logic [TRAIL_CNT_W-1:0] TRAIL_LAST = TRAIL_CNT_W'(TRAIL_CYCLES);

  hs_state_e               state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [TRAIL_CNT_W-1:0]  trail_q, trail_d;
  logic                    act_d;
  logic                    sh_load, sh_shift;
  logic [7:0]              sh_data;
  logic [1:0]              pair;

  // The shifter register doubles as the output register: trail and idle
  // levels are loaded into it so Serial_B1/B2 always come straight from flops.
  tx_hs_pair_shifter u_shifter (
    .TxDDRClkHS (TxDDRClkHS),
    .TxRst      (TxRst),
    .en         (ser_en),
    .load       (sh_load),
    .load_data  (sh_data),
    .shift      (sh_shift),
    .pair       (pair)
  );

  assign Serial_B1 = pair[0];
  assign Serial_B2 = pair[1];

  always_ff @(posedge TxDDRClkHS or posedge TxRst) begin
    if (TxRst) begin
      state_q   <= HS_IDLE;
      beat_q    <= '0;
      trail_q   <= '0;
      hs_active <= 1'b0;
    end else if (ser_en) begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      trail_q   <= trail_d;
      hs_active <= act_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    trail_d   = trail_q;
    act_d     = hs_active;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = 8'h00;
    TxReadyHS = ser_en && (state_q == HS_SYNC || state_q == HS_DATA) && (beat_q == 2'd3);

    case (state_q)
      HS_IDLE: begin
        act_d = 1'b0;
        if (TxRequestHS) begin
          state_d = HS_SYNC;
          beat_d  = '0;
          act_d   = 1'b1;
          sh_load = 1'b1;
          sh_data = SYNC_BYTE;
        end
      end
      HS_SYNC, HS_DATA: begin
        if (beat_q != 2'd3) begin
          beat_d   = beat_q + 2'd1;
          sh_shift = 1'b1;
        end else if (TxRequestHS) begin
          state_d = HS_DATA;
          beat_d  = '0;
          sh_load = 1'b1;
          sh_data = TxDataHS;
        end else begin
          // Trail level is the complement of the final bit on the wire.
          state_d = HS_TRAIL;
          beat_d  = '0;
          trail_d = TRAIL_CNT_W'(1);
          sh_load = 1'b1;
          sh_data = {8{~Serial_B2}};
        end
      end
      HS_TRAIL: begin
        if (trail_q >= TRAIL_LAST) begin
          state_d = HS_IDLE;
          trail_d = '0;
          act_d   = 1'b0;
          sh_load = 1'b1;
          sh_data = 8'h00;
        end else begin
          trail_d = trail_q + TRAIL_CNT_W'(1);
        end
      end
      default: begin
        state_d = HS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_hs_serializer.sv
// tb/tb_tx_hs_serializer.sv - randomized scoreboard bench for tx_hs_serializer (trail 4 and trail 1)
module tb_tx_hs_serializer;

  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req;
  logic [7:0] data;
  logic       rdy4, b1_4, b2_4, act4;
  logic       rdy1, b1_1, b2_1, act1;

  always #5 clk = ~clk;

  tx_hs_serializer #(.TRAIL_CYCLES(4)) dut4 (
    .TxDDRClkHS (clk),
    .TxRst      (rst),
    .ser_en     (en),
    .TxRequestHS(req),
    .TxDataHS   (data),
    .TxReadyHS  (rdy4),
    .Serial_B1  (b1_4),
    .Serial_B2  (b2_4),
    .hs_active  (act4)
  );

  tx_hs_serializer #(.TRAIL_CYCLES(1)) dut1 (
    .TxDDRClkHS (clk),
    .TxRst      (rst),
    .ser_en     (en),
    .TxRequestHS(req),
    .TxDataHS   (data),
    .TxReadyHS  (rdy1),
    .Serial_B1  (b1_1),
    .Serial_B2  (b2_1),
    .hs_active  (act1)
  );

  typedef struct packed {
    logic rdy;
    logic b1;
    logic b2;
    logic act;
  } obs_t;

  obs_t exp0[$];
  obs_t exp1[$];

  int checks = 0;
  int errors = 0;

  // Reference model: a pair queue per lane; bits leave LSB-first, two per cycle.
  bit         m_act  [2];
  int         m_tleft[2];
  logic [1:0] m_cur  [2];
  logic [1:0] m_pend [2][3];
  int         m_npend[2];
  int         m_acc  [2];

  task automatic model_reset(input int m);
    m_act[m]   = 1'b0;
    m_tleft[m] = 0;
    m_cur[m]   = 2'b00;
    m_npend[m] = 0;
  endtask

  task automatic load_byte(input int m, input logic [7:0] b);
    m_cur[m]     = b[1:0];
    m_pend[m][0] = b[3:2];
    m_pend[m][1] = b[5:4];
    m_pend[m][2] = b[7:6];
    m_npend[m]   = 3;
  endtask

  function automatic bit model_ready(input int m, input bit e);
    return e && m_act[m] && (m_tleft[m] == 0) && (m_npend[m] == 0);
  endfunction

  task automatic model_step(input int m, input int tc, input bit r, input logic [7:0] d);
    if (!m_act[m]) begin
      if (r) begin
        load_byte(m, 8'hB8);
        m_act[m] = 1'b1;
      end
    end else if (m_tleft[m] > 0) begin
      m_tleft[m]--;
      if (m_tleft[m] == 0) begin
        m_act[m] = 1'b0;
        m_cur[m] = 2'b00;
      end
    end else if (m_npend[m] > 0) begin
      m_cur[m]     = m_pend[m][0];
      m_pend[m][0] = m_pend[m][1];
      m_pend[m][1] = m_pend[m][2];
      m_npend[m]--;
    end else if (r) begin
      load_byte(m, d);
      m_acc[m]++;
    end else begin
      m_cur[m]   = {2{~m_cur[m][1]}};
      m_tleft[m] = tc;
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Monitor: one observation per cycle, mid low-phase, after inputs settle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp0.size() == 0 || exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got %0d/%0d entries expected >0", $time, exp0.size(), exp1.size());
      end else begin
        e = exp0.pop_front();
        chk("t4_ready", rdy4, e.rdy);
        chk("t4_b1",    b1_4, e.b1);
        chk("t4_b2",    b2_4, e.b2);
        chk("t4_act",   act4, e.act);
        e = exp1.pop_front();
        chk("t1_ready", rdy1, e.rdy);
        chk("t1_b1",    b1_1, e.b1);
        chk("t1_b2",    b2_1, e.b2);
        chk("t1_act",   act1, e.act);
      end
    end
  end

  initial begin
    logic [7:0] tbl [3];
    int   target;
    int   bi;
    int   acc_before;
    bit   rst_now;
    bit   rst_prev;

    tbl[0] = 8'h5A;
    tbl[1] = 8'hFF;
    tbl[2] = 8'h00;
    target   = 0;
    bi       = 0;
    rst_prev = 1'b0;
    rst  = 1'b1;
    en   = 1'b0;
    req  = 1'b0;
    data = 8'h00;
    for (int m = 0; m < 2; m++) begin
      model_reset(m);
      m_acc[m] = 0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst_now = (cyc == 0) || ($urandom_range(0, 199) == 0);
      en      = (cyc < 80) ? 1'b1 : ($urandom_range(0, 7) != 0);
      data    = (bi < 3) ? tbl[bi] : 8'($urandom);

      if (rst_now || rst_prev) begin
        req = 1'b0;
      end else if (!m_act[0]) begin
        req = ($urandom_range(0, 2) == 0);
        if (req) begin
          target   = (cyc < 80) ? ((bi < 1) ? 1 : 2) : $urandom_range(0, 3);
          m_acc[0] = 0;
        end
      end else if (m_tleft[0] > 0) begin
        req = ($urandom_range(0, 3) == 0);
      end else if (model_ready(0, en)) begin
        req = (m_acc[0] < target);
      end else begin
        req = $urandom_range(0, 1);
      end
      rst = rst_now;

      if (rst_now) begin
        model_reset(0);
        model_reset(1);
      end
      exp0.push_back('{rdy: model_ready(0, en && !rst_now), b1: m_cur[0][0], b2: m_cur[0][1], act: m_act[0]});
      exp1.push_back('{rdy: model_ready(1, en && !rst_now), b1: m_cur[1][0], b2: m_cur[1][1], act: m_act[1]});

      if (!rst_now && en) begin
        acc_before = m_acc[0];
        model_step(0, 4, req, data);
        model_step(1, 1, req, data);
        if (m_acc[0] != acc_before && bi < 3) bi++;
      end
      rst_prev = rst_now;
    end

    #3;
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp0.size(), exp1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
